// File: rtl/divider_seq_pkg.sv
// divider_seq_pkg
//   Shared definitions for the sequential multiplier/divider pair.
//   Holds the default operand widths and the divider FSM state encoding.
//   There are no ports; other files pull this in with import divider_seq_pkg::*.
package divider_seq_pkg;

  // Default widths shared by the shift-and-add multiplier and the divider.
  localparam int DIV_N = 12;
  localparam int DIV_M = 6;

  // Divider control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  // The step counter holds 0..n-1 and gets one spare bit of headroom.
  function automatic int step_cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/divider_seq_rca_nb.sv
// rca_nb
//   Generic W-bit ripple-carry adder built from a chain of full adders.
//   The divider uses it for its trial subtraction: it adds the inverted
//   divisor with the carry-in set.
// Ports
//   a, b  in   W  addends
//   cin   in   1  carry in
//   sum   out  W  a + b + cin, truncated to W bits
//   co    out  1  carry out of the top bit
module rca_nb #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         co
);

  logic [W:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign co = carry[W];

endmodule

// File: rtl/divider_seq.sv
// divider_seq
//   Sequential restoring divider. It divides an N-bit unsigned dividend by an
//   M-bit unsigned divisor and resolves one quotient bit per clock.
//   A division takes N RUN cycles followed by one FIN cycle. A zero divisor
//   skips RUN and goes straight to FIN with the divide-by-zero result.
// Ports
//   clk          in   1  system clock, rising edge
//   clr          in   1  synchronous active-high reset; takes priority over start
//   start        in   1  division request; only looked at in IDLE
//   dividend     in   N  unsigned dividend, captured on an accepted start
//   divisor      in   M  unsigned divisor, captured on an accepted start
//   busy         out  1  high while the divider is stepping (RUN)
//   done         out  1  one-cycle pulse in FIN; the results are valid from this cycle
//   div_by_zero  out  1  set when the last accepted division had a zero divisor
//   quotient     out  N  registered quotient; held until the next result
//   remainder    out  M  registered remainder; held until the next result
module divider_seq
  import divider_seq_pkg::*;
#(
  parameter int N = DIV_N,
  parameter int M = DIV_M
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [M-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output logic [N-1:0] quotient,
  output logic [M-1:0] remainder
);

  localparam int            CW        = step_cnt_width(N);
  localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

  state_t state, state_next;

  logic [N-1:0]  q;
  logic [M-1:0]  dsr;
  logic [M-1:0]  rem;
  logic [CW-1:0] cnt;

  logic [M:0]    t;
  logic [M:0]    diff;
  logic          no_borrow;
  logic [N-1:0]  q_next;
  logic [M-1:0]  rem_next;
  logic          unused_diff_msb;
  logic          last_step;

  // The partial remainder always stays below the divisor, so it fits in M
  // bits. The extra bit needed during a step exists only in the trial value t,
  // which is the remainder shifted left with the next dividend bit brought in.
  assign t = {rem, q[N-1]};

  // t - divisor, computed as t + ~divisor + 1. A carry out means there was no
  // borrow, i.e. t >= divisor.
  rca_nb #(.W(M + 1)) u_trial_sub (
    .a   (t),
    .b   (~{1'b0, dsr}),
    .cin (1'b1),
    .sum (diff),
    .co  (no_borrow)
  );

  // Keep the difference when the subtraction fits, otherwise restore t. When
  // the subtraction fits, the top bit of the difference is always zero, so it
  // is not needed.
  assign q_next          = {q[N-2:0], no_borrow};
  assign rem_next        = no_borrow ? diff[M-1:0] : t[M-1:0];
  assign unused_diff_msb = diff[M];
  assign last_step       = (cnt == LAST_STEP);

  // State register. clr forces IDLE on any state and any start value.
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A zero divisor skips RUN so that done arrives on the
  // very next cycle.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = (divisor != '0) ? ST_RUN : ST_FIN;
        end
      end
      ST_RUN: begin
        if (last_step) begin
          state_next = ST_FIN;
        end
      end
      ST_FIN:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Status outputs are decoded directly from the state register.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      ST_RUN:  busy = 1'b1;
      ST_FIN:  done = 1'b1;
      default: ;
    endcase
  end

  // Datapath and result registers. The results load on the edge that enters
  // FIN, so they are already valid while done is high. They keep their old
  // values during RUN, and a start seen outside IDLE changes nothing.
  always_ff @(posedge clk) begin
    if (clr) begin
      q           <= '0;
      dsr         <= '0;
      rem         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (divisor != '0) begin
              q           <= dividend;
              dsr         <= divisor;
              rem         <= '0;
              cnt         <= '0;
              div_by_zero <= 1'b0;
            end else begin
              quotient    <= '1;
              remainder   <= '0;
              div_by_zero <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          q   <= q_next;
          rem <= rem_next;
          cnt <= cnt + 1'b1;
          if (last_step) begin
            quotient  <= q_next;
            remainder <= rem_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_seq.sv
// tb_divider_seq
//   Scoreboard testbench for divider_seq with N=12 and M=6.
//   The driver pushes an expected result for every start it issues. A monitor
//   pops and compares whenever done is high, and also checks the latency and
//   the number of busy cycles.
module tb_divider_seq;

  localparam int N = 12;
  localparam int M = 6;

  typedef struct {
    int q;
    int r;
    int z;
    int cyc;
    int busy_n;
  } exp_t;

  logic         clk = 1'b0;
  logic         clr = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [M-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [N-1:0] quotient;
  logic [M-1:0] remainder;

  exp_t sb[$];
  int   cyc = 0;
  int   n_compared = 0;
  int   n_mismatched = 0;

  divider_seq #(.N(N), .M(M)) dut (
    .clk         (clk),
    .clr         (clr),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .quotient    (quotient),
    .remainder   (remainder)
  );

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  // Compare one value with its expected value and record the outcome.
  task automatic checkOutput(input string name, input int actual, input int expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Issue one start pulse and queue the expected result. The result is due
  // N edges after the accepting edge, or right after that edge for a zero
  // divisor.
  task automatic applyStimulus(input int dd, input int dv, input int eq, input int er, input int ez);
    exp_t e;
    @(negedge clk);
    dividend = dd[N-1:0];
    divisor  = dv[M-1:0];
    start    = 1'b1;
    e.q      = eq;
    e.r      = er;
    e.z      = ez;
    e.cyc    = cyc + 1 + ((ez != 0) ? 0 : N);
    e.busy_n = (ez != 0) ? 0 : N;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait, with a cycle limit, until every queued result has been observed.
  task automatic waitIdle();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL timeout: %0d results still pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: samples 1 unit after each rising edge. It counts busy cycles
  // and checks every done pulse against the head of the scoreboard.
  initial begin
    int   busy_cnt = 0;
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (clr) begin
        busy_cnt = 0;
      end else begin
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) begin
          if (sb.size() == 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL unexpected_done: got done=1, expected 0 (cycle %0d)", cyc);
          end else begin
            e = sb.pop_front();
            checkOutput("quotient",    int'(quotient),    e.q);
            checkOutput("remainder",   int'(remainder),   e.r);
            checkOutput("div_by_zero", int'(div_by_zero), e.z);
            checkOutput("latency",     cyc,               e.cyc);
            checkOutput("busy_cycles", busy_cnt,          e.busy_n);
          end
          busy_cnt = 0;
        end
      end
    end
  end

  initial begin
    int dd;
    int dv;

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("reset_busy",      int'(busy),        0);
    checkOutput("reset_done",      int'(done),        0);
    checkOutput("reset_quotient",  int'(quotient),    0);
    checkOutput("reset_remainder", int'(remainder),   0);
    checkOutput("reset_dbz",       int'(div_by_zero), 0);
    clr = 1'b0;

    // Basic division and operand boundaries.
    applyStimulus(100, 7, 14, 2, 0);     waitIdle();
    applyStimulus(4095, 63, 65, 0, 0);   waitIdle();
    applyStimulus(2047, 1, 2047, 0, 0);  waitIdle();
    applyStimulus(3, 9, 0, 3, 0);        waitIdle();
    applyStimulus(0, 5, 0, 0, 0);        waitIdle();

    // A zero divisor gives done on the next cycle with the saturated quotient.
    applyStimulus(5, 0, 4095, 0, 1);     waitIdle();

    // A start during RUN is ignored. The next accepted start clears div_by_zero.
    applyStimulus(100, 7, 14, 2, 0);
    repeat (3) @(negedge clk);
    dividend = 12'd50;
    divisor  = 6'd5;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitIdle();
    applyStimulus(50, 5, 10, 0, 0);      waitIdle();

    // clr in the middle of RUN aborts the division with no done pulse.
    applyStimulus(100, 7, 14, 2, 0);
    repeat (5) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    checkOutput("abort_busy",      int'(busy),        0);
    checkOutput("abort_done",      int'(done),        0);
    checkOutput("abort_quotient",  int'(quotient),    0);
    checkOutput("abort_remainder", int'(remainder),   0);
    checkOutput("abort_dbz",       int'(div_by_zero), 0);
    sb.delete();
    clr = 1'b0;
    repeat (20) @(negedge clk);
    applyStimulus(100, 7, 14, 2, 0);     waitIdle();

    // Random operand sweep.
    for (int i = 0; i < 1000; i++) begin
      dd = int'($urandom_range(0, 4095));
      dv = int'($urandom_range(1, 63));
      applyStimulus(dd, dv, dd / dv, dd % dv, 0);
      waitIdle();
    end

    repeat (5) @(negedge clk);
    checkOutput("pending_results", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
